// File: rtl/mm_pkg.sv
// Shared types and constants for the mm sequencer: FSM encoding, error codes,
// and the configuration legality check.
package mm_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StClear,
    StLoadAct,
    StLoadW,
    StGap,
    StRun,
    StWaitDone,
    StDone,
    StError
  } seq_state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CFG  = 2'd1;
  localparam logic [1:0] ERR_OVF  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  localparam int unsigned MAX_PREC = 8;

  // Illegal operands take priority over FIFO capacity.
  function automatic logic [1:0] cfg_check(input int unsigned k, input int unsigned p,
                                            input int unsigned kp, input int unsigned max_prec,
                                            input int unsigned depth);
    if (k == 0 || p == 0 || p > max_prec) return ERR_CFG;
    if (k > depth || kp > depth) return ERR_OVF;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/mm_seq_rd_pipe.sv
// One-cycle register stage turning a buffer read strobe and its data into an
// mm FIFO write strobe and data.
module mm_seq_rd_pipe #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rd_en,
  input  logic [W-1:0] rd_data,
  output logic         wr_en,
  output logic [W-1:0] wr_data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_data <= '0;
    end else begin
      wr_en <= rd_en;
      if (rd_en) wr_data <= rd_data;
    end
  end

endmodule

// File: rtl/mm_seq_ctrl.sv
// Job sequencer for the mm wrapper: clear, load activations and bit-serial
// weights, run the array, then wait for mm_done with a timeout.
module mm_seq_ctrl
  import mm_pkg::*;
#(
  parameter int unsigned ACT_WIDTH  = 16,
  parameter int unsigned N          = 2,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned KW         = 8,
  parameter int unsigned MAX_PREC   = mm_pkg::MAX_PREC,
  parameter int unsigned GAP        = 2,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [KW-1:0]          k_len,
  input  logic [3:0]             precision,
  input  logic [4:0]             exp_cfg,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [1:0]             err_code,
  output logic                   act_rd_en,
  output logic [KW-1:0]          act_rd_addr,
  input  logic [N*ACT_WIDTH-1:0] act_rd_data,
  output logic                   w_rd_en,
  output logic [KW+3:0]          w_rd_addr,
  input  logic [N-1:0]           w_rd_data,
  output logic                   mm_rst,
  output logic                   mm_wr_en_act,
  output logic [N*ACT_WIDTH-1:0] mm_act_din,
  output logic                   mm_wr_en_w,
  output logic [N-1:0]           mm_w_din,
  output logic                   mm_active,
  output logic [3:0]             mm_precision,
  output logic [4:0]             mm_exp_set,
  input  logic                   mm_done
);

  localparam int unsigned KPW = KW + 4;
  localparam int unsigned TW  = $clog2(TIMEOUT + 1);

  seq_state_e     state_q, state_d;
  logic [KW-1:0]  k_len_q;
  logic [KPW-1:0] kp_q, kp_in, cnt_q;
  logic [TW-1:0]  tmo_q;
  logic [1:0]     err_code_q, cfg_err;
  logic [3:0]     prec_q;
  logic [4:0]     exp_q;
  logic           mm_done_q, done_edge;

  assign kp_in     = KPW'(k_len) * KPW'(precision);
  assign cfg_err   = cfg_check(32'(k_len), 32'(precision), 32'(kp_in), MAX_PREC, FIFO_DEPTH);
  assign done_edge = mm_done & ~mm_done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Each load state has one trailing cycle with no read so the final write
  // drains before the next phase begins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (start) state_d = (cfg_err == ERR_NONE) ? StClear : StError;
      StClear:    state_d = StLoadAct;
      StLoadAct:  if (cnt_q == KPW'(k_len_q)) state_d = StLoadW;
      StLoadW:    if (cnt_q == kp_q) state_d = StGap;
      StGap:      if (cnt_q == KPW'(GAP - 1)) state_d = StRun;
      StRun:      if (cnt_q == kp_q - 1'b1) state_d = StWaitDone;
      StWaitDone: begin
        if (done_edge) state_d = StDone;
        else if (tmo_q == TW'(TIMEOUT - 1)) state_d = StError;
      end
      StDone, StError: state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_len_q    <= '0;
      kp_q       <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      err_code_q <= ERR_NONE;
      prec_q     <= '0;
      exp_q      <= '0;
      mm_done_q  <= 1'b0;
    end else begin
      mm_done_q <= mm_done;
      cnt_q     <= (state_d != state_q) ? '0 : cnt_q + 1'b1;
      // Counts from 1 so the timeout lands TIMEOUT cycles after the last run cycle.
      tmo_q     <= (state_q == StWaitDone) ? tmo_q + 1'b1 : TW'(1);
      if (state_q == StIdle && start) begin
        k_len_q    <= k_len;
        kp_q       <= kp_in;
        prec_q     <= precision;
        exp_q      <= exp_cfg;
        err_code_q <= cfg_err;
      end else if (state_q == StWaitDone && state_d == StError) begin
        err_code_q <= ERR_TMO;
      end
    end
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    act_rd_en = 1'b0;
    w_rd_en   = 1'b0;
    mm_active = 1'b0;
    case (state_q)
      StClear, StGap, StWaitDone: busy = 1'b1;
      StLoadAct: begin
        busy      = 1'b1;
        act_rd_en = (cnt_q < KPW'(k_len_q));
      end
      StLoadW: begin
        busy    = 1'b1;
        w_rd_en = (cnt_q < kp_q);
      end
      StRun: begin
        busy      = 1'b1;
        mm_active = 1'b1;
      end
      StDone:  done  = 1'b1;
      StError: error = 1'b1;
      default: ;
    endcase
    mm_rst      = ~rst & (state_q != StClear);
    act_rd_addr = act_rd_en ? cnt_q[KW-1:0] : '0;
    w_rd_addr   = w_rd_en ? cnt_q : '0;
  end

  assign err_code     = err_code_q;
  assign mm_precision = prec_q;
  assign mm_exp_set   = exp_q;

  mm_seq_rd_pipe #(
    .W(N * ACT_WIDTH)
  ) u_act_pipe (
    .clk    (clk),
    .rst    (rst),
    .rd_en  (act_rd_en),
    .rd_data(act_rd_data),
    .wr_en  (mm_wr_en_act),
    .wr_data(mm_act_din)
  );

  mm_seq_rd_pipe #(
    .W(N)
  ) u_w_pipe (
    .clk    (clk),
    .rst    (rst),
    .rd_en  (w_rd_en),
    .rd_data(w_rd_data),
    .wr_en  (mm_wr_en_w),
    .wr_data(mm_w_din)
  );

endmodule
